// File: rtl/i2c_regf_pkg.sv
// Shared definitions for the I2C-to-register-file transaction layer:
// FSM state encoding, request direction codes and the read-timeout filler byte.
package i2c_regf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_PTR = 3'd1,
        WR_DATA = 3'd2,
        WR_ACK  = 3'd3,
        RD_IDLE = 3'd4,
        RD_ACK  = 3'd5
    } txn_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [7:0] ERR_BYTE = 8'hFF;

    // A request is outstanding exactly while the FSM sits in one of these states.
    function automatic logic is_ack_state(input txn_state_t s);
        return (s == WR_ACK) || (s == RD_ACK);
    endfunction

endpackage

// File: rtl/regf_ack_timer.sv
// Ack-wait counter: cleared when a request is issued, advances while enabled,
// and flags done once ACK_TIMEOUT cycles have elapsed (then holds there).
module regf_ack_timer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] count;

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !done) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CW'(ACK_TIMEOUT));

endmodule

// File: rtl/regf_txn_engine.sv
// Converts the I2C slave byte stream into register-file requests: pointer byte,
// auto-incrementing data writes, on-demand reads, req/ack with timeout, sticky error.
module regf_txn_engine
    import i2c_regf_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  xfer_start,
    input  logic                  xfer_rw,
    input  logic                  xfer_stop,
    input  logic                  byte_valid,
    input  logic [DATA_WIDTH-1:0] byte_data,
    input  logic                  rd_byte_req,
    output logic [DATA_WIDTH-1:0] out_rd_byte,
    output logic                  out_rd_byte_valid,
    output logic [ADDR_WIDTH-1:0] out_regf_addr,
    output logic [DATA_WIDTH-1:0] out_regf_write_data,
    output logic                  out_regf_req,
    output logic                  out_regf_rw,
    input  logic [DATA_WIDTH-1:0] regf_read_data,
    input  logic                  regf_ack,
    output logic                  out_err
);

    txn_state_t            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  stop_pending;

    logic in_ack;
    logic restart;
    logic stop_now;
    logic wr_issue;
    logic rd_issue;
    logic timer_done;
    logic ptr_overflow;

    assign in_ack       = is_ack_state(state);
    // Start/stop are only honoured between handshakes; an open request always finishes first.
    assign restart      = xfer_start && !in_ack;
    assign stop_now     = xfer_stop && !in_ack && !restart;
    assign wr_issue     = (state == WR_DATA) && byte_valid  && !xfer_start && !xfer_stop;
    assign rd_issue     = (state == RD_IDLE) && rd_byte_req && !xfer_start && !xfer_stop;
    assign ptr_overflow = (byte_data >> ADDR_WIDTH) != '0;

    regf_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk  (clk),
        .rst  (rst),
        .load (wr_issue || rd_issue),
        .en   (in_ack),
        .done (timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            ptr                 <= '0;
            stop_pending        <= 1'b0;
            out_rd_byte         <= '0;
            out_rd_byte_valid   <= 1'b0;
            out_regf_addr       <= '0;
            out_regf_write_data <= '0;
            out_regf_req        <= 1'b0;
            out_regf_rw         <= 1'b0;
            out_err             <= 1'b0;
        end else begin
            out_rd_byte_valid <= 1'b0;

            if (restart) begin
                state        <= xfer_rw ? RD_IDLE : GET_PTR;
                out_err      <= 1'b0;
                stop_pending <= 1'b0;
            end else if (stop_now) begin
                state <= IDLE;
            end else begin
                case (state)
                    GET_PTR: begin
                        if (byte_valid) begin
                            ptr   <= byte_data[ADDR_WIDTH-1:0];
                            state <= WR_DATA;
                            if (ptr_overflow) out_err <= 1'b1;
                        end
                    end

                    WR_DATA: begin
                        if (wr_issue) begin
                            out_regf_write_data <= byte_data;
                            out_regf_addr       <= ptr;
                            out_regf_rw         <= RW_WRITE;
                            out_regf_req        <= 1'b1;
                            state               <= WR_ACK;
                        end
                    end

                    WR_ACK: begin
                        if (xfer_stop)  stop_pending <= 1'b1;
                        if (byte_valid) out_err      <= 1'b1;
                        if (regf_ack) begin
                            out_regf_req <= 1'b0;
                            ptr          <= ptr + 1'b1;
                            stop_pending <= 1'b0;
                            state        <= (stop_pending || xfer_stop) ? IDLE : WR_DATA;
                        end else if (timer_done) begin
                            out_regf_req <= 1'b0;
                            out_err      <= 1'b1;
                            stop_pending <= 1'b0;
                            state        <= (stop_pending || xfer_stop) ? IDLE : WR_DATA;
                        end
                    end

                    RD_IDLE: begin
                        if (rd_issue) begin
                            out_regf_addr <= ptr;
                            out_regf_rw   <= RW_READ;
                            out_regf_req  <= 1'b1;
                            state         <= RD_ACK;
                        end
                    end

                    RD_ACK: begin
                        if (xfer_stop)   stop_pending <= 1'b1;
                        if (rd_byte_req) out_err      <= 1'b1;
                        // Ack beats a simultaneous timeout; a timed-out read still hands the slave a byte.
                        if (regf_ack) begin
                            out_regf_req      <= 1'b0;
                            out_rd_byte       <= regf_read_data;
                            out_rd_byte_valid <= 1'b1;
                            ptr               <= ptr + 1'b1;
                            stop_pending      <= 1'b0;
                            state             <= (stop_pending || xfer_stop) ? IDLE : RD_IDLE;
                        end else if (timer_done) begin
                            out_regf_req      <= 1'b0;
                            out_rd_byte       <= DATA_WIDTH'(ERR_BYTE);
                            out_rd_byte_valid <= 1'b1;
                            out_err           <= 1'b1;
                            stop_pending      <= 1'b0;
                            state             <= (stop_pending || xfer_stop) ? IDLE : RD_IDLE;
                        end
                    end

                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regf_txn_engine.sv
// Scenario bench for regf_txn_engine: expected requests and read bytes are queued
// as stimulus is driven and popped when the DUT presents them.
module tb_regf_txn_engine;

    typedef struct packed {
        logic       rw;
        logic [3:0] addr;
        logic [7:0] data;
    } txn_t;

    logic       clk;
    logic       rst;
    logic       xfer_start;
    logic       xfer_rw;
    logic       xfer_stop;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rd_byte_req;
    logic [7:0] out_rd_byte;
    logic       out_rd_byte_valid;
    logic [3:0] out_regf_addr;
    logic [7:0] out_regf_write_data;
    logic       out_regf_req;
    logic       out_regf_rw;
    logic [7:0] regf_read_data;
    logic       regf_ack;
    logic       out_err;

    int   checks   = 0;
    int   failures = 0;
    int   req_rises = 0;
    logic req_q = 1'b0;

    txn_t       exp_q[$];
    logic [7:0] rd_q[$];

    regf_txn_engine #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .xfer_start          (xfer_start),
        .xfer_rw             (xfer_rw),
        .xfer_stop           (xfer_stop),
        .byte_valid          (byte_valid),
        .byte_data           (byte_data),
        .rd_byte_req         (rd_byte_req),
        .out_rd_byte         (out_rd_byte),
        .out_rd_byte_valid   (out_rd_byte_valid),
        .out_regf_addr       (out_regf_addr),
        .out_regf_write_data (out_regf_write_data),
        .out_regf_req        (out_regf_req),
        .out_regf_rw         (out_regf_rw),
        .regf_read_data      (regf_read_data),
        .regf_ack            (regf_ack),
        .out_err             (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count request rising edges to detect spurious or duplicated requests.
    always @(negedge clk) begin
        if (out_regf_req && !req_q) req_rises++;
        req_q = out_regf_req;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic rw);
        xfer_start = 1'b1;
        xfer_rw    = rw;
        cyc();
        xfer_start = 1'b0;
    endtask

    task automatic pulse_stop();
        xfer_stop = 1'b1;
        cyc();
        xfer_stop = 1'b0;
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        cyc();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_rdreq();
        rd_byte_req = 1'b1;
        cyc();
        rd_byte_req = 1'b0;
    endtask

    // Hold ack for one cycle after `delay` idle cycles; returns just after the acked edge.
    task automatic ack_pulse(input int delay, input logic [7:0] rdata);
        repeat (delay) cyc();
        regf_ack       = 1'b1;
        regf_read_data = rdata;
        cyc();
        regf_ack = 1'b0;
    endtask

    function automatic logic [13:0] obs_req();
        return {out_regf_req, out_regf_rw, out_regf_addr,
                out_regf_rw ? 8'h00 : out_regf_write_data};
    endfunction

    function automatic logic [13:0] want_req(input txn_t e);
        return {1'b1, e.rw, e.addr, e.rw ? 8'h00 : e.data};
    endfunction

    task automatic test_reset();
        logic [30:0] outs;
        rst = 1'b1;
        cyc();
        cyc();
        outs = {out_rd_byte, out_rd_byte_valid, out_regf_addr, out_regf_write_data,
                out_regf_req, out_regf_rw, out_err};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_multi_write();
        txn_t       e;
        logic [7:0] d;
        pulse_start(1'b0);
        pulse_byte(8'h03);
        exp_q.push_back('{rw: 1'b0, addr: 4'h3, data: 8'hA5});
        pulse_byte(8'hA5);
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL wr_req_a5: got %h expected %h", obs_req(), want_req(e));
        end
        ack_pulse(1, 8'h00);
        checks++;
        if (out_regf_req !== 1'b0) begin
            failures++;
            $display("FAIL wr_req_drop_a5: got %b expected 0", out_regf_req);
        end
        exp_q.push_back('{rw: 1'b0, addr: 4'h4, data: 8'h5A});
        pulse_byte(8'h5A);
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL wr_req_5a: got %h expected %h", obs_req(), want_req(e));
        end
        ack_pulse(1, 8'h00);
        // Final pointer is observed through a read after a repeated start.
        pulse_start(1'b1);
        exp_q.push_back('{rw: 1'b1, addr: 4'h5, data: 8'h00});
        pulse_rdreq();
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL final_ptr_read: got %h expected %h", obs_req(), want_req(e));
        end
        rd_q.push_back(8'h77);
        ack_pulse(1, 8'h77);
        d = rd_q.pop_front();
        checks++;
        if ({out_rd_byte_valid, out_rd_byte, out_regf_req} !== {1'b1, d, 1'b0}) begin
            failures++;
            $display("FAIL rd_byte_77: got v=%b b=%h req=%b expected v=1 b=%h req=0",
                     out_rd_byte_valid, out_rd_byte, out_regf_req, d);
        end
        cyc();
        checks++;
        if (out_rd_byte_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_valid_pulse: got %b expected 0", out_rd_byte_valid);
        end
        pulse_stop();
    endtask

    task automatic test_ptr_then_read();
        txn_t       e;
        logic [7:0] d;
        pulse_start(1'b0);
        pulse_byte(8'h0F);
        pulse_start(1'b1);
        exp_q.push_back('{rw: 1'b1, addr: 4'hF, data: 8'h00});
        exp_q.push_back('{rw: 1'b1, addr: 4'h0, data: 8'h00});
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h22);
        for (int i = 0; i < 2; i++) begin
            pulse_rdreq();
            e = exp_q.pop_front();
            checks++;
            if (obs_req() !== want_req(e)) begin
                failures++;
                $display("FAIL ptr_read_req%0d: got %h expected %h", i, obs_req(), want_req(e));
            end
            d = rd_q[0];
            ack_pulse(2, d);
            d = rd_q.pop_front();
            checks++;
            if ({out_rd_byte_valid, out_rd_byte} !== {1'b1, d}) begin
                failures++;
                $display("FAIL ptr_read_byte%0d: got v=%b b=%h expected v=1 b=%h",
                         i, out_rd_byte_valid, out_rd_byte, d);
            end
        end
        pulse_stop();
    endtask

    task automatic test_bad_ptr();
        txn_t e;
        pulse_start(1'b0);
        pulse_byte(8'h37);
        checks++;
        if (out_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_ptr_err: got %b expected 1", out_err);
        end
        pulse_start(1'b1);
        checks++;
        if (out_err !== 1'b0) begin
            failures++;
            $display("FAIL bad_ptr_err_clear: got %b expected 0", out_err);
        end
        exp_q.push_back('{rw: 1'b1, addr: 4'h7, data: 8'h00});
        pulse_rdreq();
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL bad_ptr_addr: got %h expected %h", obs_req(), want_req(e));
        end
        ack_pulse(0, 8'h5E);
        pulse_stop();
    endtask

    task automatic test_overrun();
        txn_t e;
        int   rises0;
        pulse_start(1'b0);
        pulse_byte(8'h02);
        rises0 = req_rises;
        exp_q.push_back('{rw: 1'b0, addr: 4'h2, data: 8'h99});
        pulse_byte(8'h99);
        e = exp_q[0];
        pulse_byte(8'hEE);
        checks++;
        if ({out_err, obs_req()} !== {1'b1, want_req(e)}) begin
            failures++;
            $display("FAIL overrun_err_hold: got %h expected %h",
                     {out_err, obs_req()}, {1'b1, want_req(e)});
        end
        e = exp_q.pop_front();
        ack_pulse(0, 8'h00);
        cyc();
        cyc();
        checks++;
        if (req_rises - rises0 !== 1) begin
            failures++;
            $display("FAIL overrun_req_count: got %0d expected 1", req_rises - rises0);
        end
        pulse_stop();
    endtask

    task automatic test_timeout();
        txn_t       e;
        logic [7:0] d;
        int         n;
        pulse_start(1'b0);
        pulse_byte(8'h06);
        pulse_start(1'b1);
        exp_q.push_back('{rw: 1'b1, addr: 4'h6, data: 8'h00});
        pulse_rdreq();
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL timeout_req: got %h expected %h", obs_req(), want_req(e));
        end
        n = 0;
        while (out_regf_req && n < 40) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles expected 16", n);
        end
        checks++;
        if ({out_rd_byte_valid, out_rd_byte, out_err} !== {1'b1, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL timeout_byte: got v=%b b=%h err=%b expected v=1 b=ff err=1",
                     out_rd_byte_valid, out_rd_byte, out_err);
        end
        exp_q.push_back('{rw: 1'b1, addr: 4'h6, data: 8'h00});
        pulse_rdreq();
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL timeout_ptr_kept: got %h expected %h", obs_req(), want_req(e));
        end
        rd_q.push_back(8'h3C);
        ack_pulse(1, 8'h3C);
        d = rd_q.pop_front();
        checks++;
        if ({out_rd_byte_valid, out_rd_byte, out_err} !== {1'b1, d, 1'b1}) begin
            failures++;
            $display("FAIL timeout_retry_byte: got v=%b b=%h err=%b expected v=1 b=%h err=1",
                     out_rd_byte_valid, out_rd_byte, out_err, d);
        end
        pulse_stop();
    endtask

    task automatic test_stop_mid();
        txn_t e;
        int   rises0;
        pulse_start(1'b0);
        pulse_byte(8'h08);
        exp_q.push_back('{rw: 1'b0, addr: 4'h8, data: 8'h42});
        pulse_byte(8'h42);
        e = exp_q.pop_front();
        pulse_stop();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL stop_wr_hold: got %h expected %h", obs_req(), want_req(e));
        end
        ack_pulse(1, 8'h00);
        checks++;
        if (out_regf_req !== 1'b0) begin
            failures++;
            $display("FAIL stop_wr_drop: got %b expected 0", out_regf_req);
        end
        rises0 = req_rises;
        pulse_byte(8'h55);
        cyc();
        cyc();
        checks++;
        if (req_rises - rises0 !== 0) begin
            failures++;
            $display("FAIL stop_idle_no_write: got %0d requests expected 0", req_rises - rises0);
        end
        pulse_start(1'b1);
        exp_q.push_back('{rw: 1'b1, addr: 4'h9, data: 8'h00});
        pulse_rdreq();
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL stop_ptr_inc: got %h expected %h", obs_req(), want_req(e));
        end
        ack_pulse(0, 8'h01);
        pulse_stop();
    endtask

    task automatic test_reset_mid();
        txn_t        e;
        logic [30:0] outs;
        pulse_start(1'b1);
        exp_q.push_back('{rw: 1'b1, addr: 4'hA, data: 8'h00});
        pulse_rdreq();
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL rst_mid_req: got %h expected %h", obs_req(), want_req(e));
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        outs = {out_rd_byte, out_rd_byte_valid, out_regf_addr, out_regf_write_data,
                out_regf_req, out_regf_rw, out_err};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got %h expected 0", outs);
        end
        pulse_start(1'b1);
        exp_q.push_back('{rw: 1'b1, addr: 4'h0, data: 8'h00});
        pulse_rdreq();
        e = exp_q.pop_front();
        checks++;
        if (obs_req() !== want_req(e)) begin
            failures++;
            $display("FAIL rst_mid_ptr_zero: got %h expected %h", obs_req(), want_req(e));
        end
        ack_pulse(0, 8'h00);
        pulse_stop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        xfer_start     = 1'b0;
        xfer_rw        = 1'b0;
        xfer_stop      = 1'b0;
        byte_valid     = 1'b0;
        byte_data      = 8'h00;
        rd_byte_req    = 1'b0;
        regf_read_data = 8'h00;
        regf_ack       = 1'b0;
        cyc();
        test_reset();
        test_multi_write();
        test_ptr_then_read();
        test_bad_ptr();
        test_overrun();
        test_timeout();
        test_stop_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
